// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared state encoding, parameter defaults and block-base helper for miss_arbiter
//
// Purpose: one place for the arbiter FSM encoding, the default geometry and the
//          rule that turns a byte address into the base of its cache block.
// Ports:   none (package).
package arb_pkg;

  localparam int NUM_REQ_DEF     = 2;   // channel 0 = I-cache, channel 1 = D-cache
  localparam int ADDR_W_DEF      = 16;
  localparam int DATA_W_DEF      = 16;
  localparam int BLOCK_WORDS_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } arb_state_e;

  // Block base = byte address with this many low bits cleared. A block holds
  // block_words two-byte words, so the offset field spans log2(2*block_words) bits.
  function automatic int unsigned block_base_lsbs(input int unsigned block_words);
    return $clog2(2 * block_words);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - winner selection for miss_arbiter
//
// Purpose: picks exactly one requester from a request vector.
//          Build option ARB_ROUND_ROBIN_EN: round-robin with an internal priority
//          pointer; otherwise fixed priority (lowest index wins, no state).
// Ports:   clk, rst_n, adv_i - clock, sync active-low reset, pointer advance
//                              (round-robin build only)
//          req_i             - request vector, one bit per channel
//          grant_o           - one-hot winner (all zero when nothing requests)
module rr_arbiter
  import arb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF
) (
`ifdef ARB_ROUND_ROBIN_EN
  input  logic               clk,
  input  logic               rst_n,
  input  logic               adv_i,
`endif
  input  logic [NUM_REQ-1:0] req_i,
  output logic [NUM_REQ-1:0] grant_o
);

  // Isolate the lowest set bit: v & -v.
  function automatic logic [NUM_REQ-1:0] lowest(input logic [NUM_REQ-1:0] v);
    return v & (~v + NUM_REQ'(1));
  endfunction

`ifdef ARB_ROUND_ROBIN_EN
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [NUM_REQ-1:0] at_or_after;
  logic [NUM_REQ-1:0] req_hi;

  always_comb begin
    at_or_after = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      at_or_after[i] = (i >= int'(ptr_q));
    end
  end

  // Prefer the lowest requester at or after the pointer; wrap to the lowest overall.
  assign req_hi  = req_i & at_or_after;
  assign grant_o = (|req_hi) ? lowest(req_hi) : lowest(req_i);

  always_comb begin
    ptr_d = ptr_q;
    if (adv_i) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (grant_o[i]) begin
          ptr_d = PTR_W'((i + 1) % NUM_REQ);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  assign grant_o = lowest(req_i);
`endif

endmodule

// File: rtl/miss_arbiter.sv
// rtl/miss_arbiter.sv - arbitrates I/D cache misses and writes onto one pipelined memory port
//
// Purpose: grants one requester at a time, streams a BLOCK_WORDS block fill or
//          performs a single-word write, then pulses done to the owner.
//          Build option ARB_ROUND_ROBIN_EN selects round-robin arbitration
//          (default build: fixed priority, channel 0 highest).
// Ports:   clk, rst_n                         - clock, sync active-low reset
//          req_valid/req_write/req_addr/req_wdata - per-channel packed requests
//          grant                              - one-hot owner of the transaction
//          fill_valid/fill_data/fill_idx      - returned words to the owner
//          done                               - one-cycle completion pulse
//          mem_en/mem_wr/mem_addr/mem_wdata   - memory command
//          mem_data_valid/mem_rdata           - in-order read return
//          busy                               - high outside IDLE
module miss_arbiter
  import arb_pkg::*;
#(
  parameter int  NUM_REQ     = NUM_REQ_DEF,
  parameter int  ADDR_W      = ADDR_W_DEF,
  parameter int  DATA_W      = DATA_W_DEF,
  parameter int  BLOCK_WORDS = BLOCK_WORDS_DEF,
  localparam int IDX_W       = $clog2(BLOCK_WORDS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        grant,
  output logic                      fill_valid,
  output logic [DATA_W-1:0]         fill_data,
  output logic [IDX_W-1:0]          fill_idx,
  output logic [NUM_REQ-1:0]        done,
  output logic                      mem_en,
  output logic                      mem_wr,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_wdata,
  input  logic                      mem_data_valid,
  input  logic [DATA_W-1:0]         mem_rdata,
  output logic                      busy
);

  localparam int OFF_W = int'(block_base_lsbs(BLOCK_WORDS));
  localparam int CNT_W = IDX_W + 1;
  localparam logic [CNT_W-1:0] NUM_WORDS = CNT_W'(BLOCK_WORDS);
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(BLOCK_WORDS - 1);

  arb_state_e         state_q, state_d;
  logic [NUM_REQ-1:0] owner_q, owner_d;
  logic               write_q, write_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic [CNT_W-1:0]   issue_q, issue_d;  // saturates at BLOCK_WORDS
  logic [CNT_W-1:0]   rx_q, rx_d;        // one bit wider than fill_idx, never wraps

  logic [NUM_REQ-1:0] arb_grant;
  logic               arb_take;
  logic               sel_write;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_wdata;
  logic               issuing;

  assign arb_take = (state_q == ST_IDLE) && (|req_valid);

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
`ifdef ARB_ROUND_ROBIN_EN
    .clk     (clk),
    .rst_n   (rst_n),
    .adv_i   (arb_take),
`endif
    .req_i   (req_valid),
    .grant_o (arb_grant)
  );

  // Route the winner's request fields; grant is one-hot so at most one matches.
  always_comb begin
    sel_write = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_grant[i]) begin
        sel_write = req_write[i];
        sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
        sel_wdata = req_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    issue_d = issue_q;
    rx_d    = rx_q;
    case (state_q)
      ST_IDLE: begin
        if (arb_take) begin
          // Request fields are captured here; later changes by the owner are ignored.
          owner_d = arb_grant;
          write_d = sel_write;
          addr_d  = sel_addr;
          wdata_d = sel_wdata;
          issue_d = '0;
          rx_d    = '0;
          state_d = sel_write ? ST_WRITE : ST_FILL;
        end
      end
      ST_FILL: begin
        if (issue_q < NUM_WORDS) begin
          issue_d = issue_q + CNT_W'(1);
        end
        if (mem_data_valid) begin
          rx_d = rx_q + CNT_W'(1);
          if (rx_q == LAST_WORD) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_WRITE: begin
        state_d = ST_DONE;
      end
      ST_DONE: begin
        owner_d = '0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      owner_q <= '0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      issue_q <= '0;
      rx_q    <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      issue_q <= issue_d;
      rx_q    <= rx_d;
    end
  end

  // Outputs are qualified by rst_n so they read zero for the whole reset
  // window, including the cycle in which reset is first sampled.
  assign issuing = (state_q == ST_FILL) && (issue_q < NUM_WORDS);
  assign mem_en  = rst_n && (issuing || (state_q == ST_WRITE));
  assign mem_wr  = rst_n && (state_q == ST_WRITE);

  always_comb begin
    mem_addr = '0;
    if (mem_en) begin
      // Fill address = block base + 2*issue count.
      mem_addr = write_q ? addr_q
                         : {addr_q[ADDR_W-1:OFF_W], issue_q[IDX_W-1:0], 1'b0};
    end
  end

  assign mem_wdata  = mem_wr ? wdata_q : '0;

  // Returned words pass straight through; anything arriving outside FILL is dropped.
  assign fill_valid = rst_n && (state_q == ST_FILL) && mem_data_valid;
  assign fill_data  = fill_valid ? mem_rdata : '0;
  assign fill_idx   = fill_valid ? rx_q[IDX_W-1:0] : '0;

  assign done  = (rst_n && (state_q == ST_DONE)) ? owner_q : '0;
  assign grant = rst_n ? owner_q : '0;
  assign busy  = rst_n && (state_q != ST_IDLE);

endmodule

// File: tb/tb_miss_arbiter.sv
// tb/tb_miss_arbiter.sv - scoreboard bench for miss_arbiter (memory latency 4)
module tb_miss_arbiter;

  localparam int NUM_REQ = 2;
  localparam int ADDR_W  = 16;
  localparam int DATA_W  = 16;
  localparam int IDX_W   = 3;
  localparam int LAT     = 4;

  logic                      clk;
  logic                      rst_n;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_write;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        grant;
  logic                      fill_valid;
  logic [DATA_W-1:0]         fill_data;
  logic [IDX_W-1:0]          fill_idx;
  logic [NUM_REQ-1:0]        done;
  logic                      mem_en;
  logic                      mem_wr;
  logic [ADDR_W-1:0]         mem_addr;
  logic [DATA_W-1:0]         mem_wdata;
  logic                      mem_data_valid;
  logic [DATA_W-1:0]         mem_rdata;
  logic                      busy;

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;

  typedef struct { int at; logic wr; logic [15:0] addr; logic [15:0] wdata; } cmd_t;
  typedef struct { int at; logic [2:0] idx; logic [15:0] data; } fill_t;
  typedef struct { int at; logic [1:0] vec; } vec_t;

  cmd_t  cmd_q[$];
  fill_t fill_q[$];
  vec_t  grant_q[$];
  vec_t  done_q[$];

  miss_arbiter dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_write      (req_write),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .grant          (grant),
    .fill_valid     (fill_valid),
    .fill_data      (fill_data),
    .fill_idx       (fill_idx),
    .done           (done),
    .mem_en         (mem_en),
    .mem_wr         (mem_wr),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_data_valid (mem_data_valid),
    .mem_rdata      (mem_rdata),
    .busy           (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic extra(input string name, input logic [63:0] act);
    n_tests++;
    n_fail++;
    $display("FAIL %s_unexpected: got %h, expected no event (cycle %0d)", name, act, cyc);
  endtask

  task automatic check_zero(input string name);
    chk(name, 64'({grant, done, fill_valid, mem_en, mem_wr, mem_addr, mem_wdata,
                   fill_data, fill_idx, busy}), 64'h0);
  endtask

  // Memory model: read data = address + 0x8000, returned LAT cycles after issue.
  logic        pipe_v [LAT];
  logic [15:0] pipe_a [LAT];
  initial begin
    mem_data_valid = 1'b0;
    mem_rdata      = '0;
    for (int i = 0; i < LAT; i++) begin
      pipe_v[i] = 1'b0;
      pipe_a[i] = '0;
    end
    forever begin
      @(posedge clk);
      #2;
      mem_data_valid = pipe_v[LAT-1];
      mem_rdata      = pipe_v[LAT-1] ? pipe_a[LAT-1] + 16'h8000 : 16'h0;
      for (int i = LAT - 1; i > 0; i--) begin
        pipe_v[i] = pipe_v[i-1];
        pipe_a[i] = pipe_a[i-1];
      end
      pipe_v[0] = mem_en && !mem_wr;
      pipe_a[0] = mem_addr;
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents an event.
  cmd_t       ce;
  fill_t      fe;
  vec_t       ve;
  logic [1:0] prev_grant = 2'b00;
  always @(negedge clk) begin
    if (mem_en) begin
      if (cmd_q.size() == 0) extra("mem_cmd", 64'({mem_wr, mem_addr, mem_wdata}));
      else begin
        ce = cmd_q.pop_front();
        chk("mem_cmd", {16'(cyc), 15'b0, mem_wr, mem_addr, (mem_wr ? mem_wdata : 16'h0)},
                       {16'(ce.at), 15'b0, ce.wr, ce.addr, ce.wdata});
      end
    end
    if (fill_valid) begin
      if (fill_q.size() == 0) extra("fill", 64'({fill_idx, fill_data}));
      else begin
        fe = fill_q.pop_front();
        chk("fill", {16'(cyc), 29'b0, fill_idx, fill_data},
                    {16'(fe.at), 29'b0, fe.idx, fe.data});
      end
    end
    if (done != 2'b00) begin
      if (done_q.size() == 0) extra("done", 64'(done));
      else begin
        ve = done_q.pop_front();
        chk("done", {16'(cyc), 46'b0, done}, {16'(ve.at), 46'b0, ve.vec});
      end
    end
    if (grant != 2'b00 && grant != prev_grant) begin
      if (grant_q.size() == 0) extra("grant", 64'(grant));
      else begin
        ve = grant_q.pop_front();
        chk("grant", {16'(cyc), 46'b0, grant}, {16'(ve.at), 46'b0, ve.vec});
      end
    end
    prev_grant = grant;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick(1);
  endtask

  task automatic set_req(input int ch, input bit v, input bit w,
                         input logic [15:0] a, input logic [15:0] d);
    req_valid[ch]          = v;
    req_write[ch]          = w;
    req_addr[ch*16 +: 16]  = a;
    req_wdata[ch*16 +: 16] = d;
  endtask

  // Fill expectations for a request presented at cycle t; base is hand-computed.
  task automatic exp_fill(input int t, input int ch, input logic [15:0] base,
                          input int ncmd, input int nret, input bit with_done);
    grant_q.push_back('{t + 1, 2'(1 << ch)});
    for (int i = 0; i < ncmd; i++)
      cmd_q.push_back('{t + 1 + i, 1'b0, base + 16'(2 * i), 16'h0});
    for (int i = 0; i < nret; i++)
      fill_q.push_back('{t + 1 + LAT + i, 3'(i), base + 16'(2 * i) + 16'h8000});
    if (with_done) done_q.push_back('{t + 13, 2'(1 << ch)});
  endtask

  task automatic exp_write(input int g, input int ch, input logic [15:0] a, input logic [15:0] d);
    grant_q.push_back('{g, 2'(1 << ch)});
    cmd_q.push_back('{g, 1'b1, a, d});
    done_q.push_back('{g + 1, 2'(1 << ch)});
  endtask

  int t;
  int own;
  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;
    tick(3);
    @(negedge clk);
    check_zero("reset_outputs");
    tick(1);
    rst_n = 1'b1;
    tick(1);
    chk("idle_busy", 64'(busy), 64'h0);

    // Single fill: channel 0, address 0x1234 -> block 0x1230.
    tick(1);
    t = cyc;
    set_req(0, 1'b1, 1'b0, 16'h1234, 16'h0);
    exp_fill(t, 0, 16'h1230, 8, 8, 1'b1);
    tick(1);
    chk("busy_fill", 64'(busy), 64'h1);
    wait_until(t + 13);
    set_req(0, 1'b0, 1'b0, 16'h0, 16'h0);
    wait_until(t + 15);

    // Single write: channel 1, 0x0040 <- 0xBEEF.
    t = cyc;
    set_req(1, 1'b1, 1'b1, 16'h0040, 16'hBEEF);
    exp_write(t + 1, 1, 16'h0040, 16'hBEEF);
    wait_until(t + 2);
    set_req(1, 1'b0, 1'b0, 16'h0, 16'h0);
    wait_until(t + 4);

    // Reset after the third returned word.
    t = cyc;
    set_req(0, 1'b1, 1'b0, 16'h2000, 16'h0);
    exp_fill(t, 0, 16'h2000, 7, 3, 1'b0);
    wait_until(t + 8);
    rst_n = 1'b0;
    set_req(0, 1'b0, 1'b0, 16'h0, 16'h0);
    wait_until(t + 9);
    @(negedge clk);
    check_zero("reset_midfill");
    wait_until(t + 10);
    rst_n = 1'b1;
    wait_until(t + 12);
    chk("idle_after_midfill_reset", 64'({busy, grant}), 64'h0);
    wait_until(t + 14);

    // Both channels hold write requests continuously.
    t = cyc;
    set_req(0, 1'b1, 1'b1, 16'h0100, 16'h1111);
    set_req(1, 1'b1, 1'b1, 16'h0200, 16'h2222);
    for (int i = 0; i < 3; i++) begin
`ifdef ARB_ROUND_ROBIN_EN
      own = i % 2;
`else
      own = 0;
`endif
      if (own == 0) exp_write(t + 1 + 3 * i, 0, 16'h0100, 16'h1111);
      else          exp_write(t + 1 + 3 * i, 1, 16'h0200, 16'h2222);
    end
    wait_until(t + 7);
    set_req(0, 1'b0, 1'b0, 16'h0, 16'h0);
    set_req(1, 1'b0, 1'b0, 16'h0, 16'h0);
    wait_until(t + 10);

    // Owner drops its request and changes address mid-fill.
    t = cyc;
    set_req(1, 1'b1, 1'b0, 16'h0457, 16'h0);
    exp_fill(t, 1, 16'h0450, 8, 8, 1'b1);
    wait_until(t + 3);
    set_req(1, 1'b0, 1'b0, 16'hFFFF, 16'h0);
    wait_until(t + 15);

    // Second request pending while the first completes.
    t = cyc;
    set_req(0, 1'b1, 1'b0, 16'h3000, 16'h0);
    exp_fill(t, 0, 16'h3000, 8, 8, 1'b1);
    exp_write(t + 15, 1, 16'h0500, 16'h5555);
    wait_until(t + 12);
    set_req(1, 1'b1, 1'b1, 16'h0500, 16'h5555);
    wait_until(t + 13);
    set_req(0, 1'b0, 1'b0, 16'h0, 16'h0);
    wait_until(t + 16);
    set_req(1, 1'b0, 1'b0, 16'h0, 16'h0);
    wait_until(t + 20);

    chk("cmd_q_left", 64'(cmd_q.size()), 64'h0);
    chk("fill_q_left", 64'(fill_q.size()), 64'h0);
    chk("grant_q_left", 64'(grant_q.size()), 64'h0);
    chk("done_q_left", 64'(done_q.size()), 64'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/miss_arbiter.md
MISS_ARBITER -- requirements
Module: miss_arbiter

Interface
REQ-001 SHALL take parameter NUM_REQ, default 2: number of cache requesters; channel 0 = I-cache, channel 1 = D-cache.
REQ-002 SHALL take parameter ADDR_W, default 16: byte address width.
REQ-003 SHALL take parameter DATA_W, default 16: memory word width.
REQ-004 SHALL take parameter BLOCK_WORDS, default 8: words per cache block; power of two, at least 2.
REQ-005 SHALL have port clk, input, width 1: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_n, input, width 1: reset, synchronous and active-low.
REQ-007 SHALL have port req_valid, input, width NUM_REQ: per-channel miss or write request, held until done.
REQ-008 SHALL have ports req_write (input, NUM_REQ), req_addr (input, NUM_REQ*ADDR_W) and req_wdata (input, NUM_REQ*DATA_W): per-channel packed request.
REQ-009 SHALL have port grant, output, width NUM_REQ: one-hot owner of the transaction in flight.
REQ-010 SHALL have ports fill_valid (output, 1), fill_data (output, DATA_W) and fill_idx (output, log2 BLOCK_WORDS): returned word routed to the granted channel.
REQ-011 SHALL have port done, output, width NUM_REQ: one-cycle completion pulse to the owner.
REQ-012 SHALL have ports mem_en (output, 1), mem_wr (output, 1), mem_addr (output, ADDR_W) and mem_wdata (output, DATA_W): memory command.
REQ-013 SHALL have ports mem_data_valid (input, 1) and mem_rdata (input, DATA_W): pipelined memory read return, in issue order, fixed unknown latency.
REQ-014 SHALL have port busy, output, width 1: high in any state other than IDLE.

Function
REQ-015 SHALL implement the states IDLE, FILL, WRITE and DONE.
REQ-016 In IDLE with any req_valid bit high, SHALL select one winner and enter FILL when its req_write is 0, or WRITE when it is 1; grant is registered and visible the next cycle.
REQ-017 SHALL issue mem_en=1, mem_wr=0 in FILL for BLOCK_WORDS consecutive cycles, starting the first FILL cycle.
REQ-018 SHALL drive those addresses as base+2*i, i=0..BLOCK_WORDS-1, where base is req_addr with its low log2(2*BLOCK_WORDS) bits cleared.
REQ-019 SHALL forward each mem_data_valid word in FILL to fill_data with fill_valid=1 and fill_idx equal to the receive count, in the same cycle (combinational pass-through).
REQ-020 SHALL go from FILL to DONE in the cycle the BLOCK_WORDS-th word is received.
REQ-021 SHALL drive mem_en=1, mem_wr=1 for exactly one cycle in WRITE, with mem_addr=req_addr and mem_wdata=req_wdata of the owner, then go to DONE.
REQ-022 SHALL, in DONE, pulse done[owner] for one cycle, deassert grant, and return to IDLE; re-arbitration happens no earlier than the next IDLE cycle.
REQ-023 SHALL latch the owner's address and data at grant; a req_valid drop or address change mid-transaction SHALL be ignored and the transaction SHALL complete.
REQ-024 SHALL ignore mem_data_valid outside FILL.
REQ-025 SHALL use wrap-free counters: the issue counter saturates at BLOCK_WORDS, and the receive counter is log2(BLOCK_WORDS)+1 bits wide.

Reset
REQ-026 SHALL, when rst_n=0 at a clock edge, including mid-FILL or mid-WRITE, force IDLE and clear the counters.
REQ-027 SHALL hold grant, done, fill_valid, mem_en, mem_wr, mem_addr, mem_wdata, fill_data, fill_idx and busy at 0 during reset.
REQ-028 SHALL discard any read data arriving after reset.

Configuration
REQ-029 With ARB_ROUND_ROBIN_EN defined, SHALL arbitrate round-robin: the priority pointer resets to 0, advances to winner+1 (mod NUM_REQ) at each grant, and the lowest index at or after the pointer wins.
REQ-030 Without ARB_ROUND_ROBIN_EN, SHALL use fixed priority: the lowest requesting index wins and no pointer state exists.

Structure
REQ-031 SHALL take its state enum, default parameter values and the block-base helper from shared package arb_pkg.
REQ-032 SHALL place winner selection in sub-module rr_arbiter (one-hot request in, one-hot grant out, pointer internal when enabled).

Verification
REQ-033 Single fill case: req_valid=01, addr 0x1234, memory latency 4, request at cycle t -> mem_addr 0x1230..0x123E at cycles t+1..t+8, fill_valid at t+5..t+12 with fill_idx 0..7, done[0] at t+13.
REQ-034 Single write case: req_valid=10, req_write=1, addr 0x0040, data 0xBEEF -> one mem_wr cycle at t+1 with 0x0040/0xBEEF, done[1] at t+2.
REQ-035 Simultaneous requests held continuously with round-robin enabled: grants alternate 01, 10, 01; with fixed priority, channel 0 is always granted.
REQ-036 Reset mid-fill: rst_n=0 after the 3rd returned word -> next cycle all outputs are 0, and the remaining returns produce no fill_valid.
REQ-037 Owner drops req_valid mid-fill: all 8 words are still issued and returned, and done still pulses.
REQ-038 Back-to-back requests: the second request, pending during DONE, is granted no earlier than the cycle after the following IDLE cycle.
